// File: rtl/f2s_pkg.sv
// Shared types and sizing helpers for the slow-domain event receiver.
package f2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } f2s_state_e;

  localparam int unsigned TMO_CYC_DEF = 64;
  localparam int unsigned TMO_W_DEF   = $clog2(TMO_CYC_DEF + 1);

  // Bits needed to hold the value n (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/slow_req_filter.sv
// Stability filter: dout follows din only after FILT_LEN consecutive equal samples.
module slow_req_filter
  import f2s_pkg::*;
#(
  parameter int unsigned FILT_LEN = 2
) (
  input  logic clk2,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned RUN_W = cnt_width(FILT_LEN);

  logic [RUN_W-1:0] run;

  // run counts consecutive samples that disagree with the current output
  always_ff @(posedge clk2) begin
    if (rst) begin
      dout <= 1'b0;
      run  <= '0;
    end else if (din != dout) begin
      if (run == RUN_W'(FILT_LEN - 1)) begin
        dout <= din;
        run  <= '0;
      end else begin
        run <= run + RUN_W'(1);
      end
    end else begin
      run <= '0;
    end
  end

endmodule

// File: rtl/slow_evt_rx_2.sv
// Slow-domain receiver for a 4-phase req/ack crossing: request -> valid/ready event, ack return, stats.
// Optional input stability filter enabled by defining SLOW_EVT_RX_FILTER_EN.
module slow_evt_rx_2
  import f2s_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TMO_CYC  = TMO_CYC_DEF,
  parameter int unsigned FILT_LEN = 2
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             sig22,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic             ack,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             cnt_wrap,
  output logic             tmo_err,
  output logic             proto_err
);

  localparam int unsigned TMO_W = cnt_width(TMO_CYC);

  logic req;

`ifdef SLOW_EVT_RX_FILTER_EN
  slow_req_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk2 (clk2),
    .rst  (rst),
    .din  (sig22),
    .dout (req)
  );
`else
  logic unused_filt_len;
  assign unused_filt_len = ^FILT_LEN;
  assign req = sig22;
`endif

  f2s_state_e       state, state_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
  logic             evt_valid_n, ack_n, cnt_wrap_n, tmo_err_n, proto_err_n;
  logic [CNT_W-1:0] evt_cnt_n;

  always_ff @(posedge clk2) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      evt_valid <= 1'b0;
      ack       <= 1'b0;
      evt_cnt   <= '0;
      cnt_wrap  <= 1'b0;
      tmo_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      tmo_cnt   <= tmo_cnt_n;
      evt_valid <= evt_valid_n;
      ack       <= ack_n;
      evt_cnt   <= evt_cnt_n;
      cnt_wrap  <= cnt_wrap_n;
      tmo_err   <= tmo_err_n;
      proto_err <= proto_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    tmo_cnt_n   = tmo_cnt;
    evt_valid_n = evt_valid;
    ack_n       = ack;
    evt_cnt_n   = evt_cnt;
    cnt_wrap_n  = cnt_wrap;
    tmo_err_n   = tmo_err;
    proto_err_n = proto_err;

    unique case (state)
      IDLE: begin
        evt_valid_n = 1'b0;
        ack_n       = 1'b0;
        if (req) begin
          state_n     = VALID;
          evt_valid_n = 1'b1;
        end
      end
      VALID: begin
        // A dropped request is flagged but the event is still delivered.
        if (!req) begin
          proto_err_n = 1'b1;
        end
        if (evt_ready) begin
          state_n     = ACK;
          evt_valid_n = 1'b0;
          ack_n       = 1'b1;
          evt_cnt_n   = evt_cnt + CNT_W'(1);
          if (&evt_cnt) begin
            cnt_wrap_n = 1'b1;
          end
        end
      end
      ACK: begin
        if (!req) begin
          state_n   = IDLE;
          ack_n     = 1'b0;
          tmo_cnt_n = '0;
        end else if (tmo_cnt < TMO_W'(TMO_CYC)) begin
          // Saturate at the limit; the handshake is never abandoned.
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
          if (tmo_cnt + TMO_W'(1) == TMO_W'(TMO_CYC)) begin
            tmo_err_n = 1'b1;
          end
        end
      end
      default: begin
        state_n     = IDLE;
        evt_valid_n = 1'b0;
        ack_n       = 1'b0;
        tmo_cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: doc/slow_evt_rx_2.md
Name: slow_evt_rx_2

Overview:
- Slow-domain (clk2) receiver for a 4-phase req/ack crossing from the fast domain.
- Input sig22 is the already-synchronized request level from the fast-to-slow synchronizer stage.
- The block does three things:
  - converts each request into one valid/ready event toward slow-domain logic;
  - drives the ack level that is returned to the fast domain;
  - keeps an event count plus sticky error flags.

Parameters:
- CNT_W, 8, width of the accepted-event counter.
- TMO_CYC, 64, clk2 cycles allowed in ACK with sig22 still high before tmo_err sets.
- FILT_LEN, 2, consecutive equal samples sig22 needs before it is accepted (only used when the filter is compiled in).

Ports:
- clk2  input  1  slow-domain clock; the block has one clock only.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk2.
- sig22  input  1  synchronized request level from the fast domain.
- evt_ready  input  1  downstream consumer ready.
- evt_valid  output  1  an event is pending for the downstream consumer.
- ack  output  1  acknowledge level, to be synchronized back to clk1.
- evt_cnt  output  CNT_W  count of accepted events (valid & ready), wraps.
- cnt_wrap  output  1  sticky; set when evt_cnt wraps from all-ones to 0.
- tmo_err  output  1  sticky; set when the ACK-phase timeout expires.
- proto_err  output  1  sticky; set when sig22 falls before the event is accepted.

Behaviour:
- Reset:
  - all outputs 0, FSM in IDLE, timeout counter 0, filter state 0.
  - Reset takes effect at the next clk2 edge. This includes mid-handshake, where ack drops on that edge.
- All outputs are registered. req denotes sig22, or the filtered sig22 when the filter is compiled in.
- FSM states are IDLE, VALID and ACK:
  - IDLE: evt_valid=0, ack=0. req=1 sampled at edge N → VALID, with evt_valid=1 from edge N+1.
  - VALID: evt_valid held at 1 until the consumer accepts.
    - evt_valid & evt_ready sampled high → evt_cnt+1, state goes to ACK, evt_valid=0 and ack=1 on the same edge.
    - If ready is already high on the first valid cycle, the event lasts exactly one cycle.
    - req=0 sampled while in VALID sets proto_err. The event is still delivered; it is never dropped.
  - ACK: ack=1.
    - While req=1, the timeout counter increments.
    - When the count reaches TMO_CYC, tmo_err sets. The FSM stays in ACK; it never abandons the handshake.
    - req=0 sampled → IDLE: ack=0 and the timeout counter clears on that edge.
    - If req is already 0 on entry, ack stays high for exactly one cycle.
- Back-to-back requests: a new req=1 is only honoured in IDLE. The minimum spacing is ack falling, then at least one IDLE cycle.
- Counter: evt_cnt wraps modulo 2^CNT_W. cnt_wrap sets on the same edge as the wrap and clears only on rst.
- Latency, sig22 rise to evt_valid rise: 1 cycle without the filter, FILT_LEN+1 cycles with it.
- Latency, acceptance to ack rise: 1 edge.
- Latency, req fall to ack fall: 1 edge (plus FILT_LEN when filtered).

Optional Feature:
- Macro: SLOW_EVT_RX_FILTER_EN.
- Defined: sig22 passes through a FILT_LEN-deep stability filter. The filtered req changes only after FILT_LEN consecutive identical samples, and it resets to 0. Glitches shorter than FILT_LEN cycles are ignored.
- Undefined: req = sig22 directly, no extra latency, and FILT_LEN is unused.

Decomposition:
- Package f2s_pkg holds:
  - the state enum typedef (IDLE, VALID, ACK);
  - the localparam default for the timeout counter width, $clog2(TMO_CYC+1).
- One sub-module, slow_req_filter, implements the optional stability filter. It is instantiated only under SLOW_EVT_RX_FILTER_EN.

Test Plan:
- Single handshake, evt_ready tied high:
  - sig22 rises at cycle 10 → evt_valid is 1 only in cycle 11 and ack=1 from cycle 12;
  - sig22 falls at cycle 20 → ack=0 at cycle 21; evt_cnt=1, all error flags 0.
- Consumer backpressure: evt_ready held low for 5 cycles → evt_valid stays high 5 cycles, ack stays 0, and evt_cnt increments once, only on acceptance.
- Wrap, CNT_W=2: 5 handshakes → evt_cnt sequence 1,2,3,0,1; cnt_wrap=1 from the 4th acceptance onward.
- Timeout, TMO_CYC=4: sig22 held high after ack → tmo_err=1 after 4 ACK cycles, ack still 1; sig22 then falls → ack=0 next cycle, tmo_err remains 1.
- Protocol error and reset:
  - sig22 pulses high for 1 cycle with evt_ready=0 → proto_err=1, the event is still delivered, then ack pulses high for 1 cycle.
  - rst asserted during ACK → next edge ack=0, evt_cnt=0, all flags 0, FSM in IDLE.
- With SLOW_EVT_RX_FILTER_EN and FILT_LEN=2:
  - a 1-cycle sig22 glitch produces no evt_valid;
  - a 3-cycle high produces evt_valid 3 cycles after the rise.
